frame_gray_writer: RTL
======================

Name: frame_gray_writer

Overview:
- Upstream stage of the SRAM filter controller.
- Accepts the camera RGB pixel stream for one frame, converts each pixel to 10-bit grayscale, and writes it to SRAM at BASE_ADDR + linear pixel index (row-major, WIDTH x HEIGHT).
- Pulses oDone when the whole frame is stored; oDone drives the filter controller's start input.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- BASE_ADDR, 0, SRAM word address of pixel (0,0).
- FIFO_DEPTH, 8, pixel FIFO entries (power of 2, >=2).

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset; synchronous, active-high.
- iStart  in  1  arm pulse; accepted in IDLE or DONE.
- iFrame_start  in  1  start-of-frame pulse from camera.
- iValid  in  1  pixel valid.
- iR, iG, iB  in  10 each  pixel components.
- oSram_addr  out  21  SRAM address.
- oSram_dq  out  16  write data, {6'b0, gray}.
- oSram_dq_en  out  1  high while this block drives dq.
- oSram_ce_n, oSram_oe_n, oSram_we_n, oSram_lb_n, oSram_ub_n  out  1 each  SRAM strobes.
- oBusy  out  1  high in ARMED, CAPTURE or DRAIN.
- oDone  out  1  one-cycle completion pulse.
- oOverflow  out  1  sticky; FIFO was full while a pixel was presented.

Behaviour:
- Reset values:
  - state IDLE; counters 0; FIFO empty.
  - oSram_addr=0, oSram_dq=0, oSram_dq_en=0.
  - oSram_ce_n=0, oSram_oe_n=0, oSram_we_n=1, oSram_lb_n=0, oSram_ub_n=0.
  - oBusy=0, oDone=0, oOverflow=0.
- Reset mid-frame abandons the frame: no further writes and no oDone.
- Gray conversion: gray = (R + 2*G + B) >> 2, with a 12-bit intermediate sum. Result is 10 bits and cannot overflow (max 1023).
- Conversion result is registered into the FIFO the cycle after iValid is sampled.
- States:
  - IDLE: iStart -> ARMED. Clears oOverflow and the pixel counters.
  - ARMED: iFrame_start -> CAPTURE. iValid is ignored while ARMED. A pixel that arrives with iValid high in the same cycle as iFrame_start is the first pixel and is accepted.
  - CAPTURE: each iValid pushes one pixel while in_count < WIDTH*HEIGHT. When in_count reaches WIDTH*HEIGHT -> DRAIN.
  - DRAIN: finish writing the remaining FIFO entries. When the FIFO is empty and no write is in flight -> DONE, with oDone high for that one cycle.
  - DONE: holds; iStart -> ARMED with counters cleared.
- Further iFrame_start pulses in CAPTURE or DRAIN are ignored (no restart).
- Extra pixels after WIDTH*HEIGHT are dropped and do not set oOverflow.
- SRAM write cycle, 2 clocks per pixel:
  - W0: pop FIFO head; drive addr = BASE_ADDR + wr_count, dq = {6'b0, gray}, dq_en=1, we_n=0.
  - W1: we_n=1; addr and data held; dq_en stays 1; wr_count increments.
  - dq_en drops the cycle after W1 unless W0 of the next pixel follows immediately. Back-to-back writes are allowed, giving 1 pixel per 2 cycles.
- oSram_oe_n=1 during W0 and W1 and 0 otherwise; ce_n, lb_n, ub_n stay 0.
- Address is generated from a linear counter; no multiplier. wr_count is 19 bits and never wraps inside a frame.
- FIFO:
  - Simultaneous push and pop is allowed.
  - A push when full and not popping drops the pixel and sets oOverflow (sticky until the next iStart).
  - Pixel count still advances on a dropped pixel, so the frame terminates on time.
  - In DRAIN, wr_count < WIDTH*HEIGHT after dropped pixels; DONE is still reached once the FIFO is empty.
- oBusy is combinational from state.

Optional Feature:
- Macro FRAME_GRAY_WRITER_STATS_EN.
- Defined:
  - Adds outputs oMin[9:0] and oMax[9:0].
  - On iStart they reset to 1023 and 0 respectively.
  - They update at every W0 with the gray value being written.
  - They are stable from the oDone pulse until the next iStart.
- Undefined: no ports and no logic for this feature.

Decomposition:
- Package filter_pkg:
  - WIDTH, HEIGHT, SRAM_AW=21, SRAM_DW=16 constants.
  - gray_t (10-bit) typedef.
  - writer_state_e enum {IDLE, ARMED, CAPTURE, DRAIN, DONE}.
- One sub-module, pixel_fifo: synchronous FIFO, parameterized by depth and data width, with full, empty, push and pop ports.

Test Plan:
- Bench parameters WIDTH=4, HEIGHT=2, BASE_ADDR=100. iStart, iFrame_start, then 8 pixels one every 3 cycles with R=G=B=4*k -> writes of gray 4*k at addresses 100..107. Each write has we_n low exactly one cycle; one oDone pulse after the last W1.
- Same setup with iValid high every cycle, FIFO_DEPTH=8 -> no overflow; writes spaced 2 cycles apart; all 8 stored.
- FIFO_DEPTH=2, 8 pixels on consecutive cycles -> oOverflow=1; fewer than 8 writes; oDone still pulses; the next iStart clears oOverflow.
- R=1023, G=1023, B=1023 -> dq=16'h03FF. R=1023, G=0, B=1 -> gray 256.
- iValid pixels while ARMED, then 10 pixels after iFrame_start -> only 8 written; the 2 extras and a mid-frame iFrame_start are ignored.
- iRst asserted after the 3rd write -> all outputs return to reset values on the next edge; no oDone; re-arm then gives a clean frame. With FRAME_GRAY_WRITER_STATS_EN, oMin and oMax match the written extremes.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types and constants for the SRAM filter path (camera writer and filter controller).
package filter_pkg;
    localparam int WIDTH   = 640;
    localparam int HEIGHT  = 480;
    localparam int SRAM_AW = 21;
    localparam int SRAM_DW = 16;
    localparam int CNT_W   = 19;

    typedef logic [9:0] gray_t;

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} writer_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_W0, WR_W1} wr_phase_e;

    // Weighted luma approximation (R + 2G + B) / 4; the 12-bit sum cannot overflow.
    function automatic gray_t rgb_to_gray(input logic [9:0] r, input logic [9:0] g,
                                          input logic [9:0] b);
        logic [11:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return gray_t'(sum >> 2);
    endfunction
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/frame_gray_writer.sv
// Captures one camera frame as 10-bit gray and writes it to SRAM, two clocks per pixel.
// Optional min/max gray statistics: define FRAME_GRAY_WRITER_STATS_EN.
module frame_gray_writer #(
    parameter int          WIDTH      = filter_pkg::WIDTH,
    parameter int          HEIGHT     = filter_pkg::HEIGHT,
    parameter logic [20:0] BASE_ADDR  = '0,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                           iClk,
    input  logic                           iRst,
    input  logic                           iStart,
    input  logic                           iFrame_start,
    input  logic                           iValid,
    input  logic [9:0]                     iR,
    input  logic [9:0]                     iG,
    input  logic [9:0]                     iB,
    output logic [filter_pkg::SRAM_AW-1:0] oSram_addr,
    output logic [filter_pkg::SRAM_DW-1:0] oSram_dq,
    output logic                           oSram_dq_en,
    output logic                           oSram_ce_n,
    output logic                           oSram_oe_n,
    output logic                           oSram_we_n,
    output logic                           oSram_lb_n,
    output logic                           oSram_ub_n,
    output logic                           oBusy,
    output logic                           oDone,
    output logic                           oOverflow
`ifdef FRAME_GRAY_WRITER_STATS_EN
    ,
    output logic [9:0]                     oMin,
    output logic [9:0]                     oMax
`endif
);
    import filter_pkg::*;

    localparam logic [CNT_W-1:0] NPIX = CNT_W'(WIDTH * HEIGHT);

    writer_state_e       state_q, state_d;
    wr_phase_e           phase_q, phase_d;
    logic [CNT_W-1:0]    in_count_q, in_count_d, wr_count_q, wr_count_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [SRAM_DW-1:0]  dq_q, dq_d;
    logic                dq_en_q, dq_en_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
    logic                done_q, done_d, ovf_q, ovf_d;
    logic                arm, accept, wr_go, fifo_full, fifo_empty;
    gray_t               pix_gray, fifo_dout;

    assign pix_gray = rgb_to_gray(iR, iG, iB);
    assign arm      = iStart && (state_q == IDLE || state_q == DONE);
    // The pixel coinciding with the frame-start pulse is the first pixel of the frame.
    assign accept   = iValid && (in_count_q < NPIX) &&
                      ((state_q == ARMED && iFrame_start) || state_q == CAPTURE);
    assign wr_go    = (phase_q != WR_W0) && !fifo_empty;

    pixel_fifo #(.DEPTH(FIFO_DEPTH), .DW($bits(gray_t))) u_fifo (
        .clk  (iClk),
        .rst  (iRst),
        .push (accept),
        .pop  (wr_go),
        .din  (pix_gray),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        in_count_d = in_count_q;
        wr_count_d = wr_count_q;
        addr_d     = addr_q;
        dq_d       = dq_q;
        dq_en_d    = dq_en_q;
        we_n_d     = we_n_q;
        oe_n_d     = oe_n_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        // A dropped pixel still counts so the frame ends on schedule.
        if (accept) begin
            in_count_d = in_count_q + 19'd1;
            if (fifo_full && !wr_go) ovf_d = 1'b1;
        end

        if (phase_q == WR_W0) begin
            phase_d    = WR_W1;
            we_n_d     = 1'b1;
            wr_count_d = wr_count_q + 19'd1;
        end else if (wr_go) begin
            phase_d = WR_W0;
            addr_d  = BASE_ADDR + {2'b00, wr_count_q};
            dq_d    = {6'b0, fifo_dout};
            dq_en_d = 1'b1;
            we_n_d  = 1'b0;
            oe_n_d  = 1'b1;
        end else begin
            phase_d = WR_IDLE;
            dq_en_d = 1'b0;
            oe_n_d  = 1'b0;
        end

        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d    = ARMED;
                    in_count_d = '0;
                    wr_count_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            ARMED: begin
                if (iFrame_start) state_d = (in_count_d == NPIX) ? DRAIN : CAPTURE;
            end
            CAPTURE: begin
                if (in_count_d == NPIX) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && phase_q == WR_IDLE) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= IDLE;
            phase_q    <= WR_IDLE;
            in_count_q <= '0;
            wr_count_q <= '0;
            addr_q     <= '0;
            dq_q       <= '0;
            dq_en_q    <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            in_count_q <= in_count_d;
            wr_count_q <= wr_count_d;
            addr_q     <= addr_d;
            dq_q       <= dq_d;
            dq_en_q    <= dq_en_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef FRAME_GRAY_WRITER_STATS_EN
    gray_t min_q, min_d, max_q, max_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (arm) begin
            min_d = '1;
            max_d = '0;
        end else if (wr_go) begin
            if (fifo_dout < min_q) min_d = fifo_dout;
            if (fifo_dout > max_q) max_d = fifo_dout;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign oMin = min_q;
    assign oMax = max_q;
`endif

    assign oSram_addr  = addr_q;
    assign oSram_dq    = dq_q;
    assign oSram_dq_en = dq_en_q;
    assign oSram_we_n  = we_n_q;
    assign oSram_oe_n  = oe_n_q;
    assign oSram_ce_n  = 1'b0;
    assign oSram_lb_n  = 1'b0;
    assign oSram_ub_n  = 1'b0;
    assign oBusy       = (state_q == ARMED) || (state_q == CAPTURE) || (state_q == DRAIN);
    assign oDone       = done_q;
    assign oOverflow   = ovf_q;
endmodule
